decoder_38_stream: RTL and testbench

- Streaming 3-to-8 one-hot decoder. It is the inverse of the team's 8-to-3 one-hot encoder and uses the same bit mapping: code 000 drives y[7], code 111 drives y[0].
- Codes arrive over a valid/ready input channel and are buffered in a small FIFO.
- Decoded one-hot words leave over a valid/ready output channel.
- It sits between a code producer (e.g. encoder output path) and one-hot select consumers.

---
 rtl/decoder_38_stream.sv | 96 +++++++++
 tb/tb_decoder_38_stream.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_38_stream.sv
// Streaming 3-to-8 one-hot decoder behind a small valid/ready FIFO (code 000 -> y[7]).
// Optional parity checking is enabled with `define DECODER_38_PARITY_CHK_EN.
module decoder_38_stream #(
  parameter int DEPTH       = 4,
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_code,
  input  logic                     in_par,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               y,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [7:0] Y_IDLE = ACTIVE_HIGH ? 8'h00 : 8'hFF;

`ifdef DECODER_38_PARITY_CHK_EN
  localparam int EW = 4;
`else
  localparam int EW = 3;
`endif

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_q;
  logic          full, empty, push, pop;
  logic [EW-1:0] entry_in, head;
  logic [2:0]    head_code;
  logic          head_err;
  logic [7:0]    y_hot;

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign push     = in_valid && !full;
  assign pop      = !empty && out_ready;
  assign in_ready = !full;
  assign out_valid = !empty;
  assign level    = level_q;

`ifdef DECODER_38_PARITY_CHK_EN
  // Odd total parity over code and parity bit marks the entry as bad.
  assign entry_in = {in_code, ^{in_code, in_par}};
`else
  logic unused_par;
  assign unused_par = in_par;
  assign entry_in   = in_code;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= entry_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Head slot cannot be overwritten while occupied: pushes are blocked when full.
  assign head      = mem[rd_ptr];
  assign head_code = head[EW-1 -: 3];
`ifdef DECODER_38_PARITY_CHK_EN
  assign head_err  = head[0];
`else
  assign head_err  = 1'b0;
`endif

  assign y_hot = 8'h80 >> head_code;

  always_comb begin
    y       = Y_IDLE;
    out_err = 1'b0;
    if (!empty) begin
      out_err = head_err;
      if (!head_err) y = ACTIVE_HIGH ? y_hot : ~y_hot;
    end
  end

endmodule

// File: tb/tb_decoder_38_stream.sv
// Randomized self-checking bench for decoder_38_stream against a queue-based model.
// Runs two instances (active-high and active-low) fed from the same stimulus.
module tb_decoder_38_stream;

  localparam int DEPTH = 4;
`ifdef DECODER_38_PARITY_CHK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_code = 3'd0;
  logic       in_par = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid, out_err;
  logic [7:0] y;
  logic [2:0] level;
  logic       in_ready_n, out_valid_n, out_err_n;
  logic [7:0] y_n;
  logic [2:0] level_n;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0] code;
    logic       err;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  decoder_38_stream #(.DEPTH(DEPTH), .ACTIVE_HIGH(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_par(in_par), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .out_err(out_err), .level(level));

  decoder_38_stream #(.DEPTH(DEPTH), .ACTIVE_HIGH(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_code(in_code), .in_par(in_par), .out_valid(out_valid_n),
    .out_ready(out_ready), .y(y_n), .out_err(out_err_n), .level(level_n));

  wire [29:0] obs = {out_valid, in_ready, level, out_err, y, y_n,
                     out_valid_n, in_ready_n, level_n, out_err_n};

  // Expected decode for a given polarity from the model's head entry.
  function automatic logic [7:0] exp_y(bit ah);
    logic [7:0] hot;
    if (q.size() == 0 || q[0].err) return ah ? 8'h00 : 8'hFF;
    hot = 8'h80 >> q[0].code;
    return ah ? hot : ~hot;
  endfunction

  function automatic logic [29:0] exp_vec();
    logic       v, r, e;
    logic [2:0] l;
    v = (q.size() != 0);
    r = (q.size() != DEPTH);
    l = 3'(q.size());
    e = v && q[0].err;
    return {v, r, l, e, exp_y(1'b1), exp_y(1'b0), v, r, l, e};
  endfunction

  // One clock: DUTs sample on the edge, model applies the same handshake rules.
  task automatic tick();
    bit push, pop;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
    end else begin
      push = in_valid && (q.size() < DEPTH);
      pop  = (q.size() > 0) && out_ready;
      if (pop) void'(q.pop_front());
      if (push) q.push_back({in_code, PAR_EN ? ^{in_code, in_par} : 1'b0});
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #3;
    checks++;
    if (obs !== {1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got=%h want=%h", obs,
               {1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 3'd0, 1'b0});
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sequence();
    logic [7:0] want;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_code = 3'(i); in_par = ^in_code;
      tick();
      want = 8'h80 >> i;
      checks++;
      if (y !== want || out_valid !== 1'b1 || out_err !== 1'b0) begin
        failures++;
        $display("FAIL seq_decode code=%0d got y=%h v=%b e=%b want y=%h v=1 e=0",
                 i, y, out_valid, out_err, want);
      end
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL seq_model got=%h want=%h", obs, exp_vec());
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (obs !== exp_vec() || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL seq_empty got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_full();
    logic [2:0] codes[5];
    for (int i = 0; i < 5; i++) codes[i] = 3'($urandom_range(0, 7));
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_code = codes[i]; in_par = ^codes[i];
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL fill_model step=%0d got=%h want=%h", i, obs, exp_vec());
      end
    end
    checks++;
    if (level !== 3'd4 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_flags got level=%0d in_ready=%b want level=4 in_ready=0", level, in_ready);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (level !== 3'd3 || y !== (8'h80 >> codes[1])) begin
      failures++;
      $display("FAIL full_pop_no_push got level=%0d y=%h want level=3 y=%h",
               level, y, 8'h80 >> codes[1]);
    end
    out_ready = 1'b0;
    tick();
    checks++;
    if (level !== 3'd4 || obs !== exp_vec()) begin
      failures++;
      $display("FAIL held_accept got=%h want=%h", obs, exp_vec());
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (y !== (8'h80 >> codes[i + 1])) begin
        failures++;
        $display("FAIL drain_order idx=%0d got=%h want=%h", i + 1, y, 8'h80 >> codes[i + 1]);
      end
      tick();
    end
    checks++;
    if (obs !== exp_vec()) begin
      failures++;
      $display("FAIL drain_empty got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_code = 3'($urandom_range(0, 7)); in_par = ^in_code;
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_code = 3'($urandom_range(0, 7)); in_par = ^in_code;
      tick();
      checks++;
      if (level !== 3'd2 || obs !== exp_vec()) begin
        failures++;
        $display("FAIL b2b cycle=%0d got=%h want=%h", i, obs, exp_vec());
      end
    end
    in_valid = 1'b0;
    tick(); tick();
  endtask

  task automatic test_polarity();
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 3'b011; in_par = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (y_n !== 8'hEF || y !== 8'h10) begin
      failures++;
      $display("FAIL polarity got y_n=%h y=%h want y_n=EF y=10", y_n, y);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (y_n !== 8'hFF || y !== 8'h00) begin
      failures++;
      $display("FAIL idle_polarity got y_n=%h y=%h want y_n=FF y=00", y_n, y);
    end
  endtask

  task automatic test_parity();
    logic [7:0] want_y;
    logic       want_e;
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 3'b011; in_par = 1'b1;
    tick();
    in_valid = 1'b0;
    want_y = PAR_EN ? 8'h00 : 8'h10;
    want_e = PAR_EN;
    checks++;
    if (y !== want_y || out_err !== want_e || level !== 3'd1) begin
      failures++;
      $display("FAIL parity_bad got y=%h err=%b level=%0d want y=%h err=%b level=1",
               y, out_err, level, want_y, want_e);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (level !== 3'd0 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL parity_pop got level=%0d err=%b want level=0 err=0", level, out_err);
    end
    out_ready = 1'b0;
    in_valid = 1'b1; in_par = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (y !== 8'h10 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL parity_good got y=%h err=%b want y=10 err=0", y, out_err);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_code = 3'($urandom_range(0, 7)); in_par = ^in_code;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (level !== 3'd3) begin
      failures++;
      $display("FAIL pre_reset_level got=%0d want=3", level);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0 || y !== 8'h00 || y_n !== 8'hFF) begin
      failures++;
      $display("FAIL async_reset got v=%b level=%0d y=%h y_n=%h want v=0 level=0 y=00 y_n=FF",
               out_valid, level, y, y_n);
    end
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1; in_code = 3'b110; in_par = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (y !== 8'h02 || obs !== exp_vec()) begin
      failures++;
      $display("FAIL post_reset got=%h want=%h", obs, exp_vec());
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(in_valid && q.size() == DEPTH)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_code  = 3'($urandom_range(0, 7));
        in_par   = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        if (errs < 10) $display("FAIL random cycle=%0d got=%h want=%h", i, obs, exp_vec());
        errs++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    checks++;
    if (obs !== exp_vec() || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL random_drain got=%h want=%h", obs, exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_full();
    test_back_to_back();
    test_polarity();
    test_parity();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
